display_scan_driver: RTL and testbench

Time-multiplexed 4-digit seven-segment driver for the microwave front panel. It sits directly downstream of the display selector. It takes the four selected BCD digits and drives shared, active-low segment lines plus one active-low anode per digit. Features: frame-coherent digit buffering, leading-zero blanking, an invalid-code dash, a colon, and a whole-display blink for the "done" and "set" modes.

---
 rtl/display_pkg.sv | 28 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/display_scan_driver.sv | 117 +++++++++++
 tb/tb_display_scan_driver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared constants for the front-panel seven-segment display: active-low glyphs
// ({g,f,e,d,c,b,a}) and anode encodings.
package display_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [1:0] scan_idx_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_OFF = 4'b1111;

  // One-hot-low anode for the digit currently being scanned.
  function automatic logic [3:0] anode_sel(input scan_idx_t idx);
    anode_sel = ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// BCD to active-low seven-segment glyph; codes above 9 render as a dash.
module seg7_decoder
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-coherent buffering,
// leading-zero blanking, colon and whole-display blink. All pins are registered.
module display_scan_driver
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       blank_lz,
  input  logic       blink_en,
  input  logic       colon_on,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_sync
);

  localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BC_MAX = BW'(BLINK_DIV - 1);

  logic [RW-1:0] rc;
  logic [BW-1:0] bc;
  scan_idx_t     idx;
  logic          phase;
  bcd_t          buf0, buf1, buf2, buf3;

  logic          tick;
  bcd_t          cur_digit;
  logic          z1, z2, z3;
  logic          blank_cur;
  logic [6:0]    dec_seg;

  assign tick = (rc == RC_MAX);

  always_comb begin
    cur_digit = buf0;
    unique case (idx)
      2'd0: cur_digit = buf0;
      2'd1: cur_digit = buf1;
      2'd2: cur_digit = buf2;
      2'd3: cur_digit = buf3;
    endcase
  end

  // Blanking chain runs from the leftmost digit; a dash counts as non-zero.
  assign z3 = (buf3 == 4'd0);
  assign z2 = z3 && (buf2 == 4'd0);
  assign z1 = z2 && (buf1 == 4'd0);

  always_comb begin
    blank_cur = 1'b0;
    unique case (idx)
      2'd0: blank_cur = 1'b0;
      2'd1: blank_cur = blank_lz && z1;
      2'd2: blank_cur = blank_lz && z2;
      2'd3: blank_cur = blank_lz && z3;
    endcase
  end

  seg7_decoder u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rc         <= '0;
      idx        <= '0;
      bc         <= '0;
      phase      <= 1'b0;
      buf0       <= '0;
      buf1       <= '0;
      buf2       <= '0;
      buf3       <= '0;
      an         <= ANODE_OFF;
      seg        <= SEG_BLANK;
      dp         <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      rc <= tick ? '0 : rc + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
      end
      if (tick && (idx == 2'd3)) begin
        buf0 <= digit0;
        buf1 <= digit1;
        buf2 <= digit2;
        buf3 <= digit3;
      end
      frame_sync <= tick && (idx == 2'd3);

      if (!blink_en) begin
        bc    <= '0;
        phase <= 1'b0;
      end else if (bc == BC_MAX) begin
        bc    <= '0;
        phase <= ~phase;
      end else begin
        bc <= bc + 1'b1;
      end

      // The tick cycle is the per-slot dead time that prevents ghosting.
      an  <= (tick || phase) ? ANODE_OFF : anode_sel(idx);
      seg <= blank_cur ? SEG_BLANK : dec_seg;
      dp  <= !((idx == 2'd2) && colon_on && !phase);
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with REFRESH_DIV = 4 and BLINK_DIV = 32.
module tb_display_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       blank_lz, blink_en, colon_on;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_sync;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  display_scan_driver #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .blank_lz   (blank_lz),
    .blink_en   (blink_en),
    .colon_on   (colon_on),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_sync (frame_sync)
  );

  typedef struct {
    logic [15:0] digits;  // {digit3, digit2, digit1, digit0}
    logic        blz;
    logic [27:0] segs;    // {seg3, seg2, seg1, seg0}
  } vec_t;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0010000, GD = 7'b0111111, GB = 7'b1111111;

  logic [3:0] an_tab [4];
  vec_t       vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_digits(input logic [15:0] d, input logic blz);
    {digit3, digit2, digit1, digit0} = d;
    blank_lz = blz;
  endtask

  // Advance to the next negedge where frame_sync is high, bounded.
  task automatic wait_fs();
    int n = 0;
    @(negedge clk);
    while (!frame_sync && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("frame_sync_seen", {31'd0, frame_sync}, 32'd1);
  endtask

  // Called at the frame_sync negedge; checks each slot's first active cycle.
  task automatic frame_check(input string name, input logic [27:0] segs);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_an%0d", name, i), {28'd0, an}, {28'd0, an_tab[i]});
      check($sformatf("%s_seg%0d", name, i), {25'd0, seg}, {25'd0, segs[i*7 +: 7]});
      if (i < 3) repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] exp_seq [5];
    int         fs_cnt;
    logic       off;
    int         rcm, im;

    an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    exp_seq = '{4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101};

    vecs[0] = '{16'h1259, 1'b0, {G1, G2, G5, G9}};
    vecs[1] = '{16'h0007, 1'b1, {GB, GB, GB, G7}};
    vecs[2] = '{16'h0000, 1'b1, {GB, GB, GB, G0}};
    vecs[3] = '{16'h0000, 1'b0, {G0, G0, G0, G0}};
    vecs[4] = '{16'h0304, 1'b1, {GB, G3, G0, G4}};
    vecs[5] = '{16'hA008, 1'b1, {GD, G0, G0, G8}};
    vecs[6] = '{16'h00F6, 1'b1, {GB, GB, GD, G6}};

    reset    = 1'b1;
    blink_en = 1'b0;
    colon_on = 1'b0;
    set_digits(16'h1259, 1'b0);

    // Reset hold
    repeat (3) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_fs", {31'd0, frame_sync}, 32'd0);

    // Startup anode sequence, buffered zero, first frame_sync at cycle 16
    reset  = 1'b0;
    fs_cnt = 0;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (k <= 5) check($sformatf("start_an%0d", k), {28'd0, an}, {28'd0, exp_seq[k-1]});
      if (k == 1) check("start_seg0", {25'd0, seg}, {25'd0, G0});
      check($sformatf("start_fs%0d", k), {31'd0, frame_sync}, {31'd0, (k % 16) == 0});
      if (frame_sync) fs_cnt++;
    end
    check("fs_count", fs_cnt, 32'd3);

    // Table of digit patterns
    foreach (vecs[v]) begin
      set_digits(vecs[v].digits, vecs[v].blz);
      wait_fs();
      frame_check($sformatf("vec%0d", v), vecs[v].segs);
    end

    // Coherency: a mid-frame change stays invisible until the next frame
    set_digits(16'h1259, 1'b0);
    wait_fs();
    wait_fs();
    @(negedge clk);
    check("coh_old0", {25'd0, seg}, {25'd0, G9});
    @(negedge clk);
    set_digits(16'hC734, 1'b0);
    repeat (3) @(negedge clk);
    check("coh_old1", {25'd0, seg}, {25'd0, G5});
    repeat (4) @(negedge clk);
    check("coh_old2", {25'd0, seg}, {25'd0, G2});
    repeat (4) @(negedge clk);
    check("coh_old3", {25'd0, seg}, {25'd0, G1});
    wait_fs();
    check("coh_fs_seg", {25'd0, seg}, {25'd0, G1});
    check("coh_fs_an", {28'd0, an}, 32'hF);
    frame_check("coh_new", {GD, G7, G3, G4});

    // Blink + colon, including a mid-period blink_en drop
    wait_fs();
    blink_en = 1'b1;
    colon_on = 1'b1;
    for (int k = 1; k <= 104; k++) begin
      @(negedge clk);
      rcm = (k - 1) % 4;
      im  = ((k - 1) / 4) % 4;
      off = (k >= 33 && k <= 64) || (k >= 97 && k <= 101);
      check($sformatf("blink_an%0d", k), {28'd0, an},
            {28'd0, (rcm == 3 || off) ? 4'hF : an_tab[im]});
      check($sformatf("blink_dp%0d", k), {31'd0, dp}, {31'd0, !(im == 2 && !off)});
      if (k == 100) blink_en = 1'b0;
    end

    // Asynchronous reset mid-slot at idx 2
    wait_fs();
    repeat (9) @(negedge clk);
    check("ar_pre_an", {28'd0, an}, 32'hB);
    check("ar_pre_dp", {31'd0, dp}, 32'd0);
    #2 reset = 1'b1;
    #1;
    check("ar_an", {28'd0, an}, 32'hF);
    check("ar_seg", {25'd0, seg}, 32'h7F);
    check("ar_dp", {31'd0, dp}, 32'd1);
    check("ar_fs", {31'd0, frame_sync}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("ar_restart_an", {28'd0, an}, 32'hE);
    check("ar_restart_seg", {25'd0, seg}, {25'd0, G0});
    repeat (3) @(negedge clk);
    check("ar_dead_an", {28'd0, an}, 32'hF);
    @(negedge clk);
    check("ar_next_an", {28'd0, an}, 32'hD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
